riscorvo_fetch: RTL and testbench

Instruction fetch stage of the riscorvo core. It drives the instruction memory valid/ready interface (valid_instr_o, addr_instr_o, ready_instr_i, data_instr_i) and buffers returned words with their PCs in a FIFO_SLOTS-deep prefetch FIFO. It hands instructions downstream to decode through a valid/ready handshake. A jump/branch redirect flushes the FIFO and restarts fetch at the new target.

---
 rtl/riscorvo_fetch.sv | 80 ++++++++
 tb/tb_riscorvo_fetch.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/riscorvo_fetch.sv
// riscorvo_fetch: instruction fetch stage with a first-word-fall-through prefetch FIFO
// and jump/branch redirect that flushes buffered words.
module riscorvo_fetch #(
    parameter int          FIFO_SLOTS    = 2,
    parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        valid_instr_o,
    output logic [31:0] addr_instr_o,
    input  logic        ready_instr_i,
    input  logic [31:0] data_instr_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    input  logic        fetch_ready_i
);
    localparam int PW = FIFO_SLOTS > 1 ? $clog2(FIFO_SLOTS) : 1;
    localparam int CW = $clog2(FIFO_SLOTS + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   mem_pc    [FIFO_SLOTS];
    logic [31:0]   mem_instr [FIFO_SLOTS];
    logic          push, pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(FIFO_SLOTS - 1) ? '0 : p + 1'b1;
    endfunction

    // Full FIFO blocks the request even when decode pops this cycle, so
    // fetch_ready_i never reaches valid_instr_o combinationally.
    assign valid_instr_o = state == RUN && count < CW'(FIFO_SLOTS) && !jump_i;
    assign addr_instr_o  = pc;
    assign push          = valid_instr_o && ready_instr_i;
    assign fetch_valid_o = count != '0;
    assign pop           = fetch_valid_o && fetch_ready_i && !jump_i;
    assign fetch_instr_o = fetch_valid_o ? mem_instr[rd_ptr] : '0;
    assign fetch_pc_o    = fetch_valid_o ? mem_pc[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            pc     <= RESET_ADDRESS;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            state <= RUN;
            if (jump_i) begin
                pc     <= {jump_addr_i[31:2], 2'b00};
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    pc     <= pc + 32'd4;
                    wr_ptr <= nxt(wr_ptr);
                end
                if (pop)
                    rd_ptr <= nxt(rd_ptr);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= pc;
            mem_instr[wr_ptr] <= data_instr_i;
        end
    end
endmodule

// File: tb/tb_riscorvo_fetch.sv
// tb_riscorvo_fetch: directed stimulus with a queue-based reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_riscorvo_fetch;
    localparam int SLOTS = 2;

    logic        clk = 0;
    logic        reset_n;
    logic        valid_instr_o;
    logic [31:0] addr_instr_o;
    logic        ready_instr_i;
    logic [31:0] data_instr_i;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        fetch_valid_o;
    logic [31:0] fetch_instr_o;
    logic [31:0] fetch_pc_o;
    logic        fetch_ready_i;

    int total = 0;
    int bad = 0;

    logic [63:0] q[$];
    logic [31:0] m_pc;
    logic        m_run;

    riscorvo_fetch #(.FIFO_SLOTS(SLOTS), .RESET_ADDRESS(32'h0)) dut (
        .clk(clk), .reset_n(reset_n),
        .valid_instr_o(valid_instr_o), .addr_instr_o(addr_instr_o),
        .ready_instr_i(ready_instr_i), .data_instr_i(data_instr_i),
        .jump_i(jump_i), .jump_addr_i(jump_addr_i),
        .fetch_valid_o(fetch_valid_o), .fetch_instr_o(fetch_instr_o),
        .fetch_pc_o(fetch_pc_o), .fetch_ready_i(fetch_ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of {pc, word}; a request exists while running with room and no redirect.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_run <= 1'b0;
            m_pc  <= 32'h0;
            q.delete();
        end else begin
            m_run <= 1'b1;
            if (jump_i) begin
                q.delete();
                m_pc <= jump_addr_i & 32'hFFFF_FFFC;
            end else if (m_run && q.size() < SLOTS && ready_instr_i) begin
                if (fetch_ready_i && q.size() != 0) void'(q.pop_front());
                q.push_back({m_pc, data_instr_i});
                m_pc <= m_pc + 32'd4;
            end else if (fetch_ready_i && q.size() != 0) begin
                void'(q.pop_front());
            end
        end
    end

    function automatic logic [63:0] head();
        return q.size() != 0 ? q[0] : 64'h0;
    endfunction

    always @(negedge clk) begin
        chk("valid_instr", 32'(valid_instr_o), 32'(m_run && q.size() < SLOTS && !jump_i));
        chk("addr_instr", addr_instr_o, m_pc);
        chk("fetch_valid", 32'(fetch_valid_o), 32'(q.size() != 0));
        chk("fetch_instr", fetch_instr_o, head()[31:0]);
        chk("fetch_pc", fetch_pc_o, head()[63:32]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 0; ready_instr_i = 1; data_instr_i = 32'h13;
        jump_i = 0; jump_addr_i = 0; fetch_ready_i = 0;
        #2;
        chk("rst_valid", 32'(valid_instr_o), 0);
        chk("rst_addr", addr_instr_o, 0);
        chk("rst_fvalid", 32'(fetch_valid_o), 0);
        chk("rst_instr", fetch_instr_o, 0);
        chk("rst_pc", fetch_pc_o, 0);
        tick(); tick();
        reset_n = 1;
        tick(); #1;
        chk("c1_valid", 32'(valid_instr_o), 1);
        chk("c1_addr", addr_instr_o, 32'h0);
        tick(); #1;
        chk("c2_fvalid", 32'(fetch_valid_o), 1);
        chk("c2_pc", fetch_pc_o, 32'h0);
        chk("c2_instr", fetch_instr_o, 32'h13);
        chk("c2_addr", addr_instr_o, 32'h4);
        tick(); #1;
        chk("full_valid", 32'(valid_instr_o), 0);
        chk("full_addr", addr_instr_o, 32'h8);
        tick(); #1;
        chk("full_hold_valid", 32'(valid_instr_o), 0);
        chk("full_hold_pc", fetch_pc_o, 32'h0);
        fetch_ready_i = 1;
        tick();
        fetch_ready_i = 0; data_instr_i = 32'h0000_0008;
        #1;
        chk("pop_pc", fetch_pc_o, 32'h4);
        chk("resume_valid", 32'(valid_instr_o), 1);
        chk("resume_addr", addr_instr_o, 32'h8);
        tick(); #1;
        chk("refill_valid", 32'(valid_instr_o), 0);
        chk("refill_addr", addr_instr_o, 32'hC);
        ready_instr_i = 0; fetch_ready_i = 1;
        tick();
        fetch_ready_i = 0;
        #1;
        chk("stall_head", fetch_pc_o, 32'h8);
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            chk("stall_valid", 32'(valid_instr_o), 1);
            chk("stall_addr", addr_instr_o, 32'hC);
        end
        data_instr_i = 32'hABCD_0001; ready_instr_i = 1;
        tick();
        ready_instr_i = 0;
        #1;
        chk("accept_full", 32'(valid_instr_o), 0);
        chk("accept_addr", addr_instr_o, 32'h10);
        jump_i = 1; jump_addr_i = 32'h0000_0102;
        #1;
        chk("jump_withdraw", 32'(valid_instr_o), 0);
        tick();
        jump_i = 0;
        #1;
        chk("jump_flush", 32'(fetch_valid_o), 0);
        chk("jump_addr", addr_instr_o, 32'h100);
        chk("jump_valid", 32'(valid_instr_o), 1);
        ready_instr_i = 1; data_instr_i = 32'h0000_0100; fetch_ready_i = 1;
        tick(); #1;
        chk("jump_first_pc", fetch_pc_o, 32'h100);
        chk("jump_first_instr", fetch_instr_o, 32'h100);
        jump_i = 1; jump_addr_i = 32'h200;
        tick();
        jump_addr_i = 32'hFFFF_FFFF;
        tick();
        jump_i = 0; fetch_ready_i = 0; data_instr_i = 32'hFFFF_0001;
        #1;
        chk("lastjump_addr", addr_instr_o, 32'hFFFF_FFFC);
        chk("lastjump_flush", 32'(fetch_valid_o), 0);
        tick();
        data_instr_i = 32'h0000_0002;
        #1;
        chk("wrap_pc0", fetch_pc_o, 32'hFFFF_FFFC);
        chk("wrap_addr", addr_instr_o, 32'h0);
        tick(); #1;
        chk("wrap_full", 32'(valid_instr_o), 0);
        fetch_ready_i = 1;
        tick();
        fetch_ready_i = 0;
        #1;
        chk("wrap_pc1", fetch_pc_o, 32'h0);
        chk("wrap_instr1", fetch_instr_o, 32'h2);
        tick();
        reset_n = 0;
        #1;
        chk("arst_valid", 32'(valid_instr_o), 0);
        chk("arst_addr", addr_instr_o, 0);
        chk("arst_fvalid", 32'(fetch_valid_o), 0);
        chk("arst_instr", fetch_instr_o, 0);
        chk("arst_pc", fetch_pc_o, 0);
        tick();
        reset_n = 1;
        tick(); #1;
        chk("restart_valid", 32'(valid_instr_o), 1);
        chk("restart_addr", addr_instr_o, 32'h0);
        for (int i = 0; i < 40; i++) begin
            tick();
            ready_instr_i = (i % 3) != 0;
            fetch_ready_i = (i % 2) == 1;
            data_instr_i = 32'h1000 + 32'(i);
            jump_i = (i == 17 || i == 30);
            jump_addr_i = i == 17 ? 32'h0000_0403 : 32'h8000_0000;
        end
        tick();
        jump_i = 0;
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
